gray_seq_checker: RTL and testbench
===================================

Name: gray_seq_checker

Overview:
- Downstream consumer of the Gray-code counter output.
- Decodes each valid Gray sample to binary with a one-cycle registered latency.
- Checks that successive samples form a legal standard-Gray sequence: +1 modulo 2^DATA_WIDTH, or an identical hold.
- Tracks lock status and counts sequence errors; sits between the counter and any logic that trusts its count.

Parameters:
- DATA_WIDTH, 4, width of Gray input and binary output.
- LOCK_CNT, 4, consecutive legal +1 steps required to assert locked (range 1..255).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- gray_in  input  DATA_WIDTH  Gray-coded sample.
- gray_valid  input  1  gray_in is valid this cycle.
- err_clr  input  1  clear err_count.
- bin_out  output  DATA_WIDTH  registered binary decode of the last accepted sample.
- bin_valid  output  1  one-cycle pulse: bin_out updated.
- locked  output  1  sequence tracked as legal for at least LOCK_CNT steps.
- err_pulse  output  1  one-cycle pulse: illegal step detected.
- err_count  output  ERR_W  saturating count of illegal steps.

Behaviour:
- Decode: b[DATA_WIDTH-1] = g[DATA_WIDTH-1]; b[i] = b[i+1] XOR g[i] for i down to 0.
- Latency: a sample accepted at edge k (gray_valid=1) drives bin_out, bin_valid=1, locked and err_pulse from edge k onward, for the following cycle. With gray_valid=0: bin_valid=0, err_pulse=0, and all state and bin_out hold.
- Internal state: have_prev flag, prev_bin register, streak counter (8 bits, saturates at LOCK_CNT), FSM {UNLOCKED, LOCKED}.
- First sample after reset (have_prev=0): capture prev_bin and set have_prev. No check, no error, streak=0.
- Step classification, with nb = decode(gray_in):
  - LEGAL: nb == prev_bin+1 mod 2^DATA_WIDTH. Wrap from all-ones to 0 is LEGAL.
  - HOLD: nb == prev_bin. Legal, streak unchanged, no error.
  - ILLEGAL: anything else, including decrement, skip, or a multi-bit Gray change.
- UNLOCKED:
  - LEGAL: streak++. When streak reaches LOCK_CNT, go to LOCKED and assert locked with that same sample.
  - ILLEGAL: streak=0, no err_pulse, no count. Errors only count while locked.
- LOCKED:
  - LEGAL/HOLD: stay.
  - ILLEGAL: err_pulse=1, err_count++ (saturates at 2^ERR_W-1), go to UNLOCKED, streak=0, locked=0.
- prev_bin is updated to nb on every accepted sample, legal or not, so resync starts from the new value.
- err_clr: err_count := 0. If err_clr and a counted error occur in the same cycle, err_count := 1. err_pulse is unaffected by err_clr.
- Reset: synchronous and active-high; dominates all inputs. After the edge: bin_out=0, bin_valid=0, locked=0, err_pulse=0, err_count=0, state UNLOCKED, have_prev=0, streak=0. Reset mid-operation discards lock and history.
- Pure RTL, no combinational path from inputs to outputs.

Decomposition:
- Shared package gray_pkg:
  - state enum {UNLOCKED, LOCKED}.
  - step-class enum {LEGAL, HOLD, ILLEGAL}.
  - function gray2bin parameterised via DATA_WIDTH.
- One combinational sub-module, gray_to_bin (DATA_WIDTH parameter), instantiated once for the incoming sample.
- FSM, streak counter and error counter live in gray_seq_checker.

Test Plan:
- Lock-in: reset, then gray 0000,0001,0011,0010,0110 on consecutive cycles. Expect bin_out 0,1,2,3,4, each one cycle later with bin_valid pulses. locked rises with the bin 4 sample (4th legal step). No err_pulse.
- Wrap: locked, feed gray 1001 (bin 14), 1000 (15), 0000 (0). Expect bin_out 14,15,0, locked stays 1, err_count 0.
- Skip error: locked at gray 0111 (bin 5), feed 0100 (bin 7). Expect err_pulse for one cycle, err_count=1, locked=0. Then 4 legal steps from 7 (gray 1100,1101,1111,1110) re-lock.
- Hold and gaps: locked at bin 5, feed 0111 twice with gray_valid=0 cycles between. Expect no error, locked stays 1, bin_valid only on valid cycles.
- Saturation and clear: ERR_W=2, force 5 lock/error cycles, err_count stays at 3. Assert err_clr in the same cycle as an error: err_count=1.
- Reset mid-run: assert reset while locked with err_count=2. Next cycle all outputs 0. The first sample after release (gray 0101) produces no error and bin_out=6.

Source files
------------

// File: rtl/gray_seq_checker_pkg.sv
// gray_pkg: shared types and the Gray-to-binary decode helper for the sequence checker
package gray_pkg;
    typedef enum logic [0:0] {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;
    typedef enum logic [1:0] {LEGAL, HOLD, ILLEGAL} step_e;
    localparam int GRAY_MAX_W = 32;
    // Decodes any width up to GRAY_MAX_W; callers zero-extend, so upper bits stay zero
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_seq_checker_if.sv
// gray_seq_checker_if: sample input and decoded/status outputs of the Gray sequence checker
interface gray_seq_checker_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ERR_W      = 8
);
    logic [DATA_WIDTH-1:0] gray_in;
    logic                  gray_valid;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] bin_out;
    logic                  bin_valid;
    logic                  locked;
    logic                  err_pulse;
    logic [ERR_W-1:0]      err_count;
    modport master (
        output gray_in, gray_valid, err_clr,
        input  bin_out, bin_valid, locked, err_pulse, err_count
    );
    modport slave (
        input  gray_in, gray_valid, err_clr,
        output bin_out, bin_valid, locked, err_pulse, err_count
    );
endinterface

// File: rtl/gray_seq_checker_gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary decoder
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);
    assign bin = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
endmodule

// File: rtl/gray_seq_checker.sv
// gray_seq_checker: decodes Gray samples and checks they step +1 (or hold), tracking lock and errors
module gray_seq_checker
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_W      = 8
) (
    input logic clk,
    input logic reset,
    gray_seq_checker_if.slave bus
);
    localparam logic [0:0] ST_UNLOCKED = 1'(UNLOCKED);
    localparam logic [0:0] ST_LOCKED   = 1'(LOCKED);
    localparam logic [7:0] LOCK_STEPS  = 8'(LOCK_CNT);

    logic [DATA_WIDTH-1:0] nb;
    logic [DATA_WIDTH-1:0] prev_bin;
    logic                  have_prev;
    logic [7:0]            streak;
    logic [0:0]            state;
    step_e                 step;
    logic                  count_err;

    gray_to_bin #(.DATA_WIDTH(DATA_WIDTH)) u_dec (.gray(bus.gray_in), .bin(nb));

    assign step = (nb == prev_bin + DATA_WIDTH'(1)) ? LEGAL :
                  (nb == prev_bin)                  ? HOLD  : ILLEGAL;
    assign count_err = bus.gray_valid && have_prev && state == ST_LOCKED && step == ILLEGAL;
    assign bus.locked = state == ST_LOCKED;

    // Decode register, history, lock FSM and streak; everything holds when no sample arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.bin_out   <= '0;
            bus.bin_valid <= 1'b0;
            bus.err_pulse <= 1'b0;
            prev_bin      <= '0;
            have_prev     <= 1'b0;
            streak        <= '0;
            state         <= ST_UNLOCKED;
        end else begin
            bus.bin_valid <= bus.gray_valid;
            bus.err_pulse <= count_err;
            if (bus.gray_valid) begin
                bus.bin_out <= nb;
                prev_bin    <= nb;
                have_prev   <= 1'b1;
                if (have_prev && state == ST_UNLOCKED && step == LEGAL) begin
                    streak <= streak + 8'd1;
                    if (streak + 8'd1 >= LOCK_STEPS) begin
                        streak <= LOCK_STEPS;
                        state  <= ST_LOCKED;
                    end
                end else if (have_prev && step == ILLEGAL) begin
                    streak <= '0;
                    state  <= ST_UNLOCKED;
                end
            end
        end
    end

    // Saturating error counter; a clear coinciding with a counted error leaves exactly one
    always_ff @(posedge clk) begin
        if (reset) bus.err_count <= '0;
        else if (bus.err_clr) bus.err_count <= ERR_W'(count_err);
        else if (count_err && bus.err_count != '1) bus.err_count <= bus.err_count + ERR_W'(1);
    end
endmodule

// File: tb/tb_gray_seq_checker.sv
// tb_gray_seq_checker: directed scoreboard bench for the Gray sequence checker
module tb_gray_seq_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] bin;
        logic       l;
        logic       e;
        logic [1:0] c;
    } exp_t;
    exp_t q[$];

    gray_seq_checker_if #(.DATA_WIDTH(4), .ERR_W(2)) bus ();
    gray_seq_checker #(.DATA_WIDTH(4), .LOCK_CNT(4), .ERR_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int b, input logic l, input logic e, input int c, input logic clr = 1'b0);
        exp_t x;
        bus.gray_in = 4'(b ^ (b >> 1));
        bus.gray_valid = 1'b1;
        bus.err_clr = clr;
        x.bin = 4'(b);
        x.l = l;
        x.e = e;
        x.c = 2'(c);
        q.push_back(x);
        @(posedge clk);
        #1;
        bus.gray_valid = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic relock(input int start, input int c);
        for (int i = 0; i < 3; i++) send((start + i) % 16, 1'b0, 1'b0, c);
        send((start + 3) % 16, 1'b1, 1'b0, c);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_bin_out"}, int'(bus.bin_out), 0);
        chk({tag, "_bin_valid"}, int'(bus.bin_valid), 0);
        chk({tag, "_locked"}, int'(bus.locked), 0);
        chk({tag, "_err_pulse"}, int'(bus.err_pulse), 0);
        chk({tag, "_err_count"}, int'(bus.err_count), 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t x;
        if (bus.bin_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_bin_valid", 1, 0);
            end else begin
                x = q.pop_front();
                chk("bin_out", int'(bus.bin_out), int'(x.bin));
                chk("locked", int'(bus.locked), int'(x.l));
                chk("err_pulse", int'(bus.err_pulse), int'(x.e));
                chk("err_count", int'(bus.err_count), int'(x.c));
            end
        end else begin
            chk("idle_err_pulse", int'(bus.err_pulse), 0);
        end
    end

    initial begin
        bus.gray_in = '0;
        bus.gray_valid = 1'b0;
        bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        // lock-in: bins 0..4, lock on the 4th legal step
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);
        send(2, 0, 0, 0);
        send(3, 0, 0, 0);
        send(4, 1, 0, 0);
        // run through the wrap 15 -> 0 while locked
        for (int b = 5; b < 16; b++) send(b, 1, 0, 0);
        send(0, 1, 0, 0);
        for (int b = 1; b < 6; b++) send(b, 1, 0, 0);
        // holds of bin 5 separated by idle gaps
        idle(2);
        send(5, 1, 0, 0);
        idle(1);
        send(5, 1, 0, 0);
        idle(1);
        // skip 5 -> 7, then re-lock from 7
        send(7, 0, 1, 1);
        relock(8, 1);
        // saturation of the 2-bit error counter
        send(13, 0, 1, 2);
        relock(14, 2);
        send(3, 0, 1, 3);
        relock(4, 3);
        send(9, 0, 1, 3);
        relock(10, 3);
        send(15, 0, 1, 3);
        // illegal and hold while unlocked: no error, streak restarts
        send(3, 0, 0, 3);
        send(3, 0, 0, 3);
        relock(4, 3);
        // clear together with a counted error leaves one
        send(9, 0, 1, 1, 1'b1);
        relock(10, 1);
        send(15, 0, 1, 2);
        relock(0, 2);
        idle(1);
        // reset while locked with two errors recorded
        reset = 1'b1;
        idle(1);
        check_reset_state("midreset");
        reset = 1'b0;
        send(6, 0, 0, 0);
        relock(7, 0);
        send(12, 0, 1, 1);
        // standalone clear on an idle cycle
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        send(13, 0, 0, 0);
        idle(2);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
